// File: rtl/trace_logger_mc_if.sv
// Memory-side bus of the trace logger: write port, read port and the
// access strobes the memory arbiter hands to the logger.
interface trace_logger_mc_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
);
  localparam int AW = $clog2(DEPTH);

  logic             RW_TURN_I;
  logic             WRITE_ALLOW_I;
  logic             READ_ALLOW_I;
  logic             WRITE_O;
  logic [AW-1:0]    WRITE_PTR_O;
  logic [WIDTH-1:0] DMEM_O;
  logic [AW-1:0]    READ_PTR_O;
  logic [WIDTH-1:0] DMEM_I;

  // Logger side: drives addresses, write data and write enable.
  modport master (
    input  RW_TURN_I, WRITE_ALLOW_I, READ_ALLOW_I, DMEM_I,
    output WRITE_O, WRITE_PTR_O, DMEM_O, READ_PTR_O
  );

  // Memory/arbiter side.
  modport slave (
    output RW_TURN_I, WRITE_ALLOW_I, READ_ALLOW_I, DMEM_I,
    input  WRITE_O, WRITE_PTR_O, DMEM_O, READ_PTR_O
  );
endinterface

// File: rtl/trace_logger_mc.sv
// Trace logger: skid FIFO in front of a circular trace memory, with an
// arm/capture FSM (trace mode) or plain FIFO behaviour (streaming mode),
// saturating drop counter and oldest-first readout.
//
// Handshakes:
//   store : STORE_PERM_O is a ready, STORE_I a valid; a word transfers in a
//           cycle where both are high. STORE_I without ready while capturing
//           is a lost word and bumps DROP_COUNT_O.
//   write : WRITE_O is a single-cycle commit; WRITE_PTR_O/DMEM_O are valid
//           whenever WRITE_O is high.
//   load  : LOAD_REQUEST_I pulses a request that stays pending until it is
//           served; LOAD_GRANT_O pulses once with DATA_O valid in that cycle.
module trace_logger_mc #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 1024,
  parameter int DELAY_BITS  = 3,
  parameter int SFIFO_DEPTH = 2,
  parameter int DROP_BITS   = 16,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  MODE_I,
  input  logic [DELAY_BITS-1:0] DELAY_I,
  input  logic                  ARM_I,
  trace_logger_mc_if.master     mem,
  input  logic                  TRG_EVENT_I,
  output logic                  TRG_DELAYED_O,
  output logic [AW-1:0]         EVENT_ADDR_O,
  input  logic [WIDTH-1:0]      DATA_I,
  input  logic                  STORE_I,
  output logic                  STORE_PERM_O,
  output logic [WIDTH-1:0]      DATA_O,
  input  logic                  LOAD_REQUEST_I,
  output logic                  LOAD_GRANT_O,
  output logic [AW:0]           FILL_O,
  output logic [DROP_BITS-1:0]  DROP_COUNT_O,
  output logic [1:0]            STATE_O
);

  localparam int SW = $clog2(SFIFO_DEPTH);
  localparam int PW = AW + DELAY_BITS + 1;
  localparam logic [AW:0] FULL_FILL = (AW+1)'(DEPTH);
  localparam logic [SW:0] SF_FULL   = (SW+1)'(SFIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_TRIG  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  logic                   r_mode;
  logic [PW-1:0]          r_post;
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [AW:0]            r_fill;
  logic [AW-1:0]          r_event_addr;
  logic [DROP_BITS-1:0]   r_drop;
  logic [WIDTH-1:0]       r_data_o;
  logic                   r_grant;
  logic                   r_pending;
  logic [WIDTH-1:0]       r_fifo [SFIFO_DEPTH];
  logic [SW-1:0]          r_fhead;
  logic [SW-1:0]          r_ftail;
  logic [SW:0]            r_fcount;

  logic                   w_accept;
  logic                   w_fifo_empty;
  logic                   w_fifo_full;
  logic                   w_wvalid;
  logic                   w_rvalid;
  logic                   w_write;
  logic                   w_read;
  logic                   w_perm;
  logic                   w_push;
  logic                   w_drop;
  logic [PW-1:0]          w_post_calc;
  logic [AW-1:0]          w_wptr_nxt;
  logic [AW:0]            w_fill_nxt;

  // Post-trigger commit budget, scaled from the delay ratio at full width.
  assign w_post_calc = ((PW'(DELAY_I) + PW'(1)) * PW'(DEPTH - 1)) >> DELAY_BITS;

  assign w_accept     = (r_state == S_ARMED) || (r_state == S_TRIG);
  assign w_fifo_empty = (r_fcount == '0);
  assign w_fifo_full  = (r_fcount == SF_FULL);
  // Trace mode overwrites circularly; streaming mode stops at a full memory.
  assign w_wvalid     = r_mode ? (r_fill != FULL_FILL) : 1'b1;
  assign w_rvalid     = (r_fill != '0) &&
                        (r_mode ? (r_state == S_ARMED) : (r_state == S_DONE));

  // ARM_I and RST_I override everything, so no memory traffic in those cycles.
  assign w_write = ~RST_I & ~ARM_I & ~w_fifo_empty & mem.RW_TURN_I &
                   mem.WRITE_ALLOW_I & w_wvalid & w_accept;
  assign w_read  = ~RST_I & ~ARM_I & r_pending & mem.RW_TURN_I &
                   mem.READ_ALLOW_I & w_rvalid;
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign w_perm  = ~RST_I & ~ARM_I & w_accept & (~w_fifo_full | w_write);
  assign w_push  = STORE_I & w_perm;
  assign w_drop  = STORE_I & w_accept & ~w_perm & ~ARM_I;

  assign w_wptr_nxt = r_wptr + AW'(1);

  // Fill level after this cycle's commit/read.
  always_comb begin
    w_fill_nxt = r_fill;
    if (w_write && !w_read) begin
      w_fill_nxt = (r_fill == FULL_FILL) ? r_fill : r_fill + (AW+1)'(1);
    end else if (!w_write && w_read) begin
      w_fill_nxt = r_fill - (AW+1)'(1);
    end
  end

  // Skid FIFO storage; occupancy is tracked in the control block.
  always_ff @(posedge CLK_I) begin
    if (w_push) r_fifo[r_ftail] <= DATA_I;
  end

  // Capture FSM plus pointer, fill, drop and readout bookkeeping.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state      <= S_IDLE;
      r_mode       <= 1'b0;
      r_post       <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_fill       <= '0;
      r_event_addr <= '0;
      r_drop       <= '0;
      r_data_o     <= '0;
      r_grant      <= 1'b0;
      r_pending    <= 1'b0;
      r_fhead      <= '0;
      r_ftail      <= '0;
      r_fcount     <= '0;
    end else if (ARM_I) begin
      r_state   <= S_ARMED;
      r_mode    <= MODE_I;
      r_post    <= w_post_calc;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_fill    <= '0;
      r_drop    <= '0;
      r_grant   <= 1'b0;
      r_pending <= 1'b0;
      r_fhead   <= '0;
      r_ftail   <= '0;
      r_fcount  <= '0;
    end else begin
      r_grant   <= w_read;
      r_pending <= (r_pending & ~w_read) | LOAD_REQUEST_I;
      if (w_read) begin
        r_data_o <= mem.DMEM_I;
        r_rptr   <= r_rptr + AW'(1);
      end
      if (w_push) r_ftail <= r_ftail + SW'(1);
      if (w_write) r_fhead <= r_fhead + SW'(1);
      r_fcount <= r_fcount + (SW+1)'(w_push) - (SW+1)'(w_write);
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + DROP_BITS'(1);
      if (w_write) r_wptr <= w_wptr_nxt;
      r_fill <= w_fill_nxt;

      case (r_state)
        S_IDLE: ;
        S_ARMED: begin
          if (!r_mode && TRG_EVENT_I) begin
            r_event_addr <= r_wptr;
            r_state      <= S_TRIG;
          end
        end
        S_TRIG: begin
          if (w_write) begin
            if (r_post != '0) begin
              r_post <= r_post - PW'(1);
            end else begin
              r_state <= S_DONE;
              // Oldest surviving entry once the final commit has landed.
              r_rptr  <= w_wptr_nxt - w_fill_nxt[AW-1:0];
            end
          end
        end
        S_DONE: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem.WRITE_O     = w_write;
  assign mem.WRITE_PTR_O = r_wptr;
  assign mem.DMEM_O      = r_fifo[r_fhead];
  assign mem.READ_PTR_O  = r_rptr;

  assign TRG_DELAYED_O = (r_state == S_DONE);
  assign EVENT_ADDR_O  = r_event_addr;
  assign STORE_PERM_O  = w_perm;
  assign DATA_O        = r_data_o;
  assign LOAD_GRANT_O  = r_grant;
  assign FILL_O        = r_fill;
  assign DROP_COUNT_O  = r_drop;
  assign STATE_O       = r_state;

endmodule

// File: tb/tb_trace_logger_mc.sv
// Bench for trace_logger_mc at DEPTH=16, DELAY_BITS=3, SFIFO_DEPTH=2,
// DROP_BITS=4, with a behavioural dual-port memory on the bus interface.
module tb_trace_logger_mc;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int DELAY_BITS = 3;
  localparam int SFIFO_DEPTH = 2;
  localparam int DROP_BITS = 4;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        MODE_I;
  logic [2:0]  DELAY_I;
  logic        ARM_I;
  logic        TRG_EVENT_I;
  logic        TRG_DELAYED_O;
  logic [3:0]  EVENT_ADDR_O;
  logic [31:0] DATA_I;
  logic        STORE_I;
  logic        STORE_PERM_O;
  logic [31:0] DATA_O;
  logic        LOAD_REQUEST_I;
  logic        LOAD_GRANT_O;
  logic [4:0]  FILL_O;
  logic [3:0]  DROP_COUNT_O;
  logic [1:0]  STATE_O;

  trace_logger_mc_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  trace_logger_mc #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .DELAY_BITS(DELAY_BITS),
    .SFIFO_DEPTH(SFIFO_DEPTH), .DROP_BITS(DROP_BITS)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .MODE_I(MODE_I), .DELAY_I(DELAY_I),
    .ARM_I(ARM_I), .mem(bus), .TRG_EVENT_I(TRG_EVENT_I),
    .TRG_DELAYED_O(TRG_DELAYED_O), .EVENT_ADDR_O(EVENT_ADDR_O),
    .DATA_I(DATA_I), .STORE_I(STORE_I), .STORE_PERM_O(STORE_PERM_O),
    .DATA_O(DATA_O), .LOAD_REQUEST_I(LOAD_REQUEST_I),
    .LOAD_GRANT_O(LOAD_GRANT_O), .FILL_O(FILL_O),
    .DROP_COUNT_O(DROP_COUNT_O), .STATE_O(STATE_O)
  );

  // Clock
  always #5 CLK_I = ~CLK_I;

  // Trace memory: synchronous write, combinational read.
  logic [31:0] mem_q [DEPTH];
  always @(posedge CLK_I) begin
    if (bus.WRITE_O === 1'b1) mem_q[bus.WRITE_PTR_O] <= bus.DMEM_O;
  end
  assign bus.DMEM_I = mem_q[bus.READ_PTR_O];

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic [2:0] delay;
    int         exp_commits;
    int         exp_fill;
    logic [3:0] exp_event;
    int         exp_first;
  } cap_vec_t;
  cap_vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK_I);
    @(negedge CLK_I);
  endtask

  task automatic arm(input logic m, input logic [2:0] d);
    ARM_I = 1'b1; MODE_I = m; DELAY_I = d; STORE_I = 1'b0; TRG_EVENT_I = 1'b0;
    cyc();
    ARM_I = 1'b0;
  endtask

  task automatic read_one(output logic got, output logic [31:0] d);
    LOAD_REQUEST_I = 1'b1;
    cyc();
    LOAD_REQUEST_I = 1'b0;
    got = 1'b0;
    d = '0;
    for (int t = 0; t < 8 && !got; t++) begin
      cyc();
      if (LOAD_GRANT_O) begin
        got = 1'b1;
        d = DATA_O;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        got;
    logic [31:0] d;
    int          commits;
    int          grants;
    logic        trig_done;

    vecs[0] = '{3'd0, 2, 2, 4'd0, 0};
    vecs[1] = '{3'd1, 4, 4, 4'd0, 0};
    vecs[2] = '{3'd3, 8, 8, 4'd0, 0};
    vecs[3] = '{3'd7, 16, 16, 4'd0, 0};

    for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
    RST_I = 1'b1; MODE_I = 1'b0; DELAY_I = '0; ARM_I = 1'b0; TRG_EVENT_I = 1'b0;
    DATA_I = '0; STORE_I = 1'b0; LOAD_REQUEST_I = 1'b0;
    bus.RW_TURN_I = 1'b0; bus.WRITE_ALLOW_I = 1'b0; bus.READ_ALLOW_I = 1'b0;
    @(negedge CLK_I);
    cyc();
    cyc();
    RST_I = 1'b0;
    cyc();

    // Reset state, and stores in IDLE are neither accepted nor counted.
    chk("rst_state", 32'(STATE_O), 0);
    chk("rst_fill", 32'(FILL_O), 0);
    chk("rst_wptr", 32'(bus.WRITE_PTR_O), 0);
    chk("rst_rptr", 32'(bus.READ_PTR_O), 0);
    chk("rst_grant", 32'(LOAD_GRANT_O), 0);
    chk("rst_trgd", 32'(TRG_DELAYED_O), 0);
    bus.RW_TURN_I = 1'b1; bus.WRITE_ALLOW_I = 1'b1; bus.READ_ALLOW_I = 1'b1;
    STORE_I = 1'b1; DATA_I = 32'd7;
    #1;
    chk("idle_perm", 32'(STORE_PERM_O), 0);
    chk("idle_write", 32'(bus.WRITE_O), 0);
    cyc();
    STORE_I = 1'b0;
    chk("idle_drop", 32'(DROP_COUNT_O), 0);

    // Streaming: fill memory, then the skid FIFO, then lose one word.
    arm(1'b1, 3'd0);
    for (int k = 0; k < 19; k++) begin
      STORE_I = 1'b1; DATA_I = 32'(k);
      cyc();
    end
    STORE_I = 1'b0;
    #1;
    chk("str_fill", 32'(FILL_O), 16);
    chk("str_drop", 32'(DROP_COUNT_O), 1);
    chk("str_state", 32'(STATE_O), 1);
    chk("str_write_blocked", 32'(bus.WRITE_O), 0);
    chk("str_perm_full", 32'(STORE_PERM_O), 0);
    read_one(got, d);
    chk("str_grant", 32'(got), 1);
    chk("str_data", d, 0);
    chk("str_resume_write", 32'(bus.WRITE_O), 1);
    chk("str_resume_word", bus.DMEM_O, 16);
    cyc();
    chk("str_refill", 32'(FILL_O), 16);

    // Half rate: stores only in cycles without a memory turn.
    arm(1'b0, 3'd0);
    for (int i = 0; i < 20; i++) begin
      bus.RW_TURN_I = (i % 2 == 1); STORE_I = (i % 2 == 0); DATA_I = 32'(i);
      cyc();
    end
    STORE_I = 1'b0;
    chk("half_drop", 32'(DROP_COUNT_O), 0);
    chk("half_fill", 32'(FILL_O), 10);

    // Full rate against a half-rate memory turn: drops, then saturation.
    arm(1'b0, 3'd0);
    for (int i = 0; i < 20; i++) begin
      bus.RW_TURN_I = (i % 2 == 1); STORE_I = 1'b1; DATA_I = 32'(i);
      cyc();
    end
    chk("full_drop", 32'(DROP_COUNT_O), 8);
    for (int i = 20; i < 40; i++) begin
      bus.RW_TURN_I = (i % 2 == 1); STORE_I = 1'b1; DATA_I = 32'(i);
      cyc();
    end
    STORE_I = 1'b0;
    chk("drop_saturate", 32'(DROP_COUNT_O), 15);
    chk("fill_saturate", 32'(FILL_O), 16);

    // ARM beats a same-cycle trigger and store (FIFO was full here).
    ARM_I = 1'b1; MODE_I = 1'b0; DELAY_I = 3'd3; TRG_EVENT_I = 1'b1;
    STORE_I = 1'b1; DATA_I = 32'd99; bus.RW_TURN_I = 1'b1;
    cyc();
    ARM_I = 1'b0; TRG_EVENT_I = 1'b0; STORE_I = 1'b0;
    #1;
    chk("arm_state", 32'(STATE_O), 1);
    chk("arm_wptr", 32'(bus.WRITE_PTR_O), 0);
    chk("arm_rptr", 32'(bus.READ_PTR_O), 0);
    chk("arm_fill", 32'(FILL_O), 0);
    chk("arm_drop", 32'(DROP_COUNT_O), 0);
    chk("arm_fifo_empty", 32'(bus.WRITE_O), 0);
    chk("arm_perm", 32'(STORE_PERM_O), 1);
    cyc();
    chk("arm_state_hold", 32'(STATE_O), 1);

    // Table: trigger with the first store, count commits to DONE, read back.
    for (int v = 0; v < 4; v++) begin
      arm(1'b0, vecs[v].delay);
      commits = 0;
      STORE_I = 1'b1; DATA_I = 32'd0; TRG_EVENT_I = 1'b1;
      #1;
      if (bus.WRITE_O) commits++;
      cyc();
      TRG_EVENT_I = 1'b0;
      for (int k = 1; k < 60 && STATE_O != 2'd3; k++) begin
        DATA_I = 32'(k);
        #1;
        if (bus.WRITE_O) commits++;
        cyc();
      end
      STORE_I = 1'b0;
      chk("cap_state", 32'(STATE_O), 3);
      chk("cap_trgd", 32'(TRG_DELAYED_O), 1);
      chk("cap_commits", 32'(commits), 32'(vecs[v].exp_commits));
      chk("cap_fill", 32'(FILL_O), 32'(vecs[v].exp_fill));
      chk("cap_event", 32'(EVENT_ADDR_O), 32'(vecs[v].exp_event));
      for (int j = 0; j < vecs[v].exp_fill; j++) begin
        read_one(got, d);
        chk("cap_grant", 32'(got), 1);
        chk("cap_word", d, 32'(vecs[v].exp_first + j));
      end
      chk("cap_drained", 32'(FILL_O), 0);
    end

    // Request with nothing left to read is never granted.
    LOAD_REQUEST_I = 1'b1;
    cyc();
    LOAD_REQUEST_I = 1'b0;
    grants = 0;
    for (int t = 0; t < 6; t++) begin
      cyc();
      if (LOAD_GRANT_O) grants++;
    end
    chk("empty_no_grant", 32'(grants), 0);

    // Trace capture across a wrap: trigger on the commit of word 20.
    arm(1'b0, 3'd3);
    trig_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      STORE_I = 1'b1; DATA_I = 32'(k); TRG_EVENT_I = 1'b0;
      #1;
      if (!trig_done && bus.WRITE_O && bus.DMEM_O == 32'd20) begin
        TRG_EVENT_I = 1'b1;
        trig_done = 1'b1;
      end
      cyc();
    end
    STORE_I = 1'b0; TRG_EVENT_I = 1'b0;
    chk("wrap_state", 32'(STATE_O), 3);
    chk("wrap_event", 32'(EVENT_ADDR_O), 4);
    chk("wrap_fill", 32'(FILL_O), 16);
    chk("wrap_wptr", 32'(bus.WRITE_PTR_O), 13);
    for (int j = 0; j < 16; j++) begin
      read_one(got, d);
      chk("wrap_grant", 32'(got), 1);
      chk("wrap_word", d, 32'(13 + j));
    end

    // Reset while TRIGGERED with a read pending.
    arm(1'b0, 3'd7);
    for (int k = 0; k < 3; k++) begin
      STORE_I = 1'b1; DATA_I = 32'(100 + k);
      cyc();
    end
    TRG_EVENT_I = 1'b1;
    cyc();
    TRG_EVENT_I = 1'b0; STORE_I = 1'b0;
    chk("pre_rst_state", 32'(STATE_O), 2);
    LOAD_REQUEST_I = 1'b1;
    cyc();
    LOAD_REQUEST_I = 1'b0;
    cyc();
    chk("pre_rst_pending_no_grant", 32'(LOAD_GRANT_O), 0);
    RST_I = 1'b1;
    cyc();
    RST_I = 1'b0;
    #1;
    chk("mid_rst_state", 32'(STATE_O), 0);
    chk("mid_rst_fill", 32'(FILL_O), 0);
    chk("mid_rst_wptr", 32'(bus.WRITE_PTR_O), 0);
    chk("mid_rst_rptr", 32'(bus.READ_PTR_O), 0);
    chk("mid_rst_event", 32'(EVENT_ADDR_O), 0);
    chk("mid_rst_data", DATA_O, 0);
    chk("mid_rst_trgd", 32'(TRG_DELAYED_O), 0);
    chk("mid_rst_perm", 32'(STORE_PERM_O), 0);
    chk("mid_rst_write", 32'(bus.WRITE_O), 0);
    grants = 0;
    for (int t = 0; t < 6; t++) begin
      if (LOAD_GRANT_O) grants++;
      cyc();
    end
    chk("mid_rst_no_grant", 32'(grants), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/trace_logger_mc.md
Name: trace_logger_mc

Overview:
Parametrised next-generation trace logger between the tracer and the dual-port trace memory. It buffers tracer stores in a small skid FIFO and writes them to a circular memory. It supports trace mode (circular pre/post-trigger capture with programmable split) and streaming mode (true FIFO with fill level). It adds an explicit arm/capture FSM, drop counting and readout of captured data oldest-first.

Parameters:
WIDTH, 32, data word width of tracer and memory
DEPTH, 1024, memory entries; power of two, >=4
DELAY_BITS, 3, width of trigger-delay config
SFIFO_DEPTH, 2, store skid FIFO entries; power of two, >=2
DROP_BITS, 16, width of saturating drop counter

Ports:
CLK_I  in  1  clock
RST_I  in  1  synchronous reset, active-high
MODE_I  in  1  0 = trace, 1 = streaming; sampled on ARM_I
DELAY_I  in  DELAY_BITS  post-trigger ratio; sampled on ARM_I
ARM_I  in  1  start/restart capture (single-cycle pulse)
RW_TURN_I  in  1  memory access strobe
WRITE_ALLOW_I  in  1  memory write permitted
READ_ALLOW_I  in  1  memory read permitted
WRITE_O  in/out: out  1  memory write enable
WRITE_PTR_O  out  clog2(DEPTH)  memory write address
DMEM_O  out  WIDTH  memory write data
READ_PTR_O  out  clog2(DEPTH)  memory read address
DMEM_I  in  WIDTH  memory read data at READ_PTR_O, same cycle
TRG_EVENT_I  in  1  trigger event from tracer
TRG_DELAYED_O  out  1  capture complete (state DONE)
EVENT_ADDR_O  out  clog2(DEPTH)  write address at trigger
DATA_I  in  WIDTH  trace word from tracer
STORE_I  in  1  push DATA_I
STORE_PERM_O  out  1  store would be accepted
DATA_O  out  WIDTH  word read back to tracer
LOAD_REQUEST_I  in  1  tracer read request
LOAD_GRANT_O  out  1  DATA_O valid, one-cycle pulse
FILL_O  out  clog2(DEPTH)+1  valid entries in memory
DROP_COUNT_O  out  DROP_BITS  stores lost, saturating
STATE_O  out  2  IDLE=0, ARMED=1, TRIGGERED=2, DONE=3

Behaviour:
- Reset: state IDLE. Pointers, FILL_O, DROP_COUNT_O, EVENT_ADDR_O, DATA_O, LOAD_GRANT_O, pending_read and the skid FIFO are 0/empty. WRITE_O=0, TRG_DELAYED_O=0, STORE_PERM_O=0.
- ARM_I (any state, wins over every same-cycle event): latch mode and delay, clear pointers/fill/FIFO/drop/pending_read, post <= ((DELAY_I+1)*(DEPTH-1)) >> DELAY_BITS computed at width clog2(DEPTH)+DELAY_BITS+1. Next state ARMED.
- Skid FIFO: accepts only in ARMED/TRIGGERED. STORE_PERM_O = accepting state and FIFO not full. STORE_I with perm pushes; without perm in ARMED/TRIGGERED, DROP_COUNT_O+1 (saturate at all-ones). STORE_I in IDLE/DONE is ignored, not counted.
- Memory write: WRITE_O = FIFO non-empty & RW_TURN_I & WRITE_ALLOW_I & wvalid & state in {ARMED, TRIGGERED}. DMEM_O = FIFO head (combinational). Commit pops the FIFO and sets write_ptr <= write_ptr+1 mod DEPTH. A push and pop in the same cycle is allowed when full.
- Trace mode: wvalid=1 (circular overwrite). FILL_O += 1 per commit, saturating at DEPTH.
- ARMED: TRG_EVENT_I=1 -> EVENT_ADDR_O <= write_ptr; go TRIGGERED. A same-cycle commit still occurs.
- TRIGGERED: a commit with post>0 decrements post; a commit with post==0 -> DONE. After the trigger, exactly post+1 commits land.
- DONE: TRG_DELAYED_O=1. On entry, read_ptr <= write_ptr-FILL (oldest entry, mod DEPTH). rvalid = FILL>0; each read decrements FILL.
- Streaming mode: trigger ignored; state stays ARMED. wvalid = FILL<DEPTH; rvalid = FILL>0. Read and write in the same cycle leave FILL unchanged.
- Read: LOAD_REQUEST_I sets pending_read. If pending & RW_TURN_I & READ_ALLOW_I & rvalid: DATA_O <= DMEM_I, LOAD_GRANT_O=1 next cycle, read_ptr+1 mod DEPTH, pending cleared. Otherwise LOAD_GRANT_O=0. A request in IDLE, ARMED or TRIGGERED (trace mode) stays pending until DONE.
- Reset mid-capture aborts everything to the reset state; memory contents are not cleared.

Test Plan:
- DEPTH=16, DELAY_BITS=3, trace, DELAY_I=3 (post=7); stream words 0..39, trigger at word 20 -> EVENT_ADDR_O=4, DONE after word 28, FILL_O=16, readout yields 13..28 in order.
- Trace, DELAY_I=7 (post=15); trigger on first store -> 16 post words stored, readout starts at the trigger word.
- Streaming, DEPTH=16; 16 stores, no reads -> FILL_O=16, WRITE_O=0, FIFO fills, 3rd extra store dropped, DROP_COUNT_O=1. One read -> grant with word 0, writing resumes.
- RW_TURN_I toggling every other cycle with continuous STORE_I, SFIFO_DEPTH=2 -> no drops at half rate, drops counted at full rate.
- ARM_I asserted in the same cycle as TRG_EVENT_I and STORE_I -> trigger ignored, store not counted, state ARMED, pointers 0.
- RST_I pulse while TRIGGERED with a pending read -> all outputs at reset values next cycle, STATE_O=0, no grant.
